ef_tcc_mc: RTL and testbench

EF_TCC_MC -- requirements
Module: ef_tcc_mc

---
 rtl/ef_tcc_mc_pkg.sv | 33 +++
 rtl/ef_tcc_mc_sync_edge.sv | 38 +++
 rtl/ef_tcc_mc.sv | 249 ++++++++++++++++++++++++
 tb/tb_ef_tcc_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_tcc_mc_pkg.sv
// ef_tcc_mc_pkg -- shared encodings for the timer/counter/compare/capture block.
// Contents:
//   dir_e       counting-direction encoding (reserved code behaves as up)
//   cap_edge_e  per-channel capture-edge selection
//   FLAG_TO, flag_match(i), flag_cap(i, ch)  bit positions inside ris/mis/im/icr
package ef_tcc_mc_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN = 2'b00,
        DIR_UP   = 2'b01,
        DIR_UPDN = 2'b10,
        DIR_RSVD = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        CAP_OFF  = 2'b00,
        CAP_RISE = 2'b01,
        CAP_FALL = 2'b10,
        CAP_BOTH = 2'b11
    } cap_edge_e;

    // Timeout flag sits at bit 0; match flags follow, then capture flags.
    localparam int FLAG_TO = 0;

    function automatic int flag_match(input int i);
        return 1 + i;
    endfunction

    function automatic int flag_cap(input int i, input int ch);
        return 1 + ch + i;
    endfunction

endpackage

// File: rtl/ef_tcc_mc_sync_edge.sv
// ef_tcc_mc_sync_edge -- two-flop synchronizer for an asynchronous input plus
// a history flop that turns the synchronized level into one-cycle edge pulses.
// An input edge shows up as a pulse after the second clock and is consumed on
// the third clock edge.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   d           asynchronous input
//   rise, fall  one-cycle pulses on the synchronized rising / falling edge
module ef_tcc_mc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain (s1_r, s2_r) and previous-level history (s3_r)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Pulses are decoded from flops only, so they are glitch-free.
    assign rise = s2_r & ~s3_r;
    assign fall = ~s2_r & s3_r;

endmodule

// File: rtl/ef_tcc_mc.sv
// ef_tcc_mc -- general-purpose timer with prescaler or external count source,
// up / down / up-down counting, one-shot mode, CH compare (PWM) channels and
// CH capture channels, sticky interrupt flags with mask and clear.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, tmr_en          block enable, counter run (0 = load start value)
//   one_shot, dir       stop after first timeout, count direction
//   clk_src, pre        0: prescaled clk (tick every pre+1), 1: ext_clk rise
//   period, cmp         terminal count and compare values (shadowed)
//   cap_edge, cap_in    capture edge selects and asynchronous capture inputs
//   ext_clk             asynchronous external count source
//   im, icr             interrupt mask, one-cycle flag-clear pulses
//   cnt, cap_val, pwm   counter, captured counts, compare outputs
//   ris, mis, irq       raw flags, masked flags, interrupt request
//   running             counter active (cleared by a one-shot timeout)
module ef_tcc_mc
    import ef_tcc_mc_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int CH = 4,
    parameter  int PW = 8,
    localparam int NF = 1 + 2 * CH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            tmr_en,
    input  logic            one_shot,
    input  logic [1:0]      dir,
    input  logic            clk_src,
    input  logic [PW-1:0]   pre,
    input  logic [W-1:0]    period,
    input  logic [CH*W-1:0] cmp,
    input  logic [2*CH-1:0] cap_edge,
    input  logic            ext_clk,
    input  logic [CH-1:0]   cap_in,
    input  logic [NF-1:0]   im,
    input  logic [NF-1:0]   icr,
    output logic [W-1:0]    cnt,
    output logic [CH*W-1:0] cap_val,
    output logic [CH-1:0]   pwm,
    output logic [NF-1:0]   ris,
    output logic [NF-1:0]   mis,
    output logic            irq,
    output logic            running
);

    localparam logic [W-1:0]  ONE_W  = W'(1'b1);
    localparam logic [W-1:0]  ZERO_W = {W{1'b0}};
    localparam logic [PW-1:0] ONE_P  = PW'(1'b1);

    dir_e              dir_s;
    logic [CH:0]       sync_d_s;
    logic [CH:0]       rise_s;
    logic [CH:0]       fall_s;
    logic [CH:0]       ev_s;
    logic [2*CH+1:0]   edge_sel_s;
    logic [PW-1:0]     pre_cnt_r;
    logic              pre_hit_s;
    logic              tick_s;
    logic              to_s;
    logic [W-1:0]      cnt_r;
    logic [W-1:0]      cnt_nx;
    logic [W-1:0]      per_sh_r;
    logic [W-1:0]      per_sh_nx;
    logic [CH*W-1:0]   cmp_sh_r;
    logic [CH*W-1:0]   cmp_sh_nx;
    logic [CH*W-1:0]   cap_val_r;
    logic [CH*W-1:0]   cap_val_nx;
    logic              phase_r;
    logic              phase_nx;
    logic              running_r;
    logic              run_nx;
    logic [CH-1:0]     pwm_r;
    logic [CH-1:0]     pwm_nx;
    logic [CH-1:0]     match_s;
    logic [CH-1:0]     cap_s;
    logic [NF-1:0]     ris_r;
    logic [NF-1:0]     set_s;

    assign dir_s = dir_e'(dir);

    // Slot 0 carries ext_clk (rising edge only); slots 1..CH carry cap_in.
    assign sync_d_s   = {cap_in, ext_clk};
    assign edge_sel_s = {cap_edge, CAP_RISE};

    for (genvar k = 0; k <= CH; k++) begin : g_sync
        ef_tcc_mc_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (sync_d_s[k]),
            .rise  (rise_s[k]),
            .fall  (fall_s[k])
        );
    end

    // Qualify each synchronized edge with its edge selection
    always_comb begin
        ev_s = {(CH+1){1'b0}};
        for (int k = 0; k <= CH; k++) begin
            ev_s[k] = (edge_sel_s[2*k] & rise_s[k]) | (edge_sel_s[2*k+1] & fall_s[k]);
        end
    end

    assign pre_hit_s = (pre_cnt_r == pre);
    assign tick_s    = en & tmr_en & running_r & (clk_src ? ev_s[0] : pre_hit_s);

    // Prescaler: counts 0..pre and restarts whenever the timer is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PW{1'b0}};
        end else if (!en || !tmr_en || pre_hit_s) begin
            pre_cnt_r <= {PW{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + ONE_P;
        end
    end

    // Counter next state, up/down phase, shadow reload and one-shot stop
    always_comb begin
        cnt_nx    = cnt_r;
        phase_nx  = phase_r;
        run_nx    = running_r;
        per_sh_nx = per_sh_r;
        cmp_sh_nx = cmp_sh_r;
        to_s      = 1'b0;
        if (!tmr_en) begin
            // Idle: preload start value and keep shadows transparent.
            if (en) begin
                cnt_nx = (dir_s == DIR_DOWN) ? period : ZERO_W;
            end else begin
                cnt_nx = cnt_r;
            end
            phase_nx  = 1'b0;
            run_nx    = 1'b1;
            per_sh_nx = period;
            cmp_sh_nx = cmp;
        end else if (tick_s) begin
            case (dir_s)
                DIR_DOWN: begin
                    if (cnt_r == ZERO_W) begin
                        to_s   = 1'b1;
                        cnt_nx = period;
                    end else begin
                        cnt_nx = cnt_r - ONE_W;
                    end
                end
                DIR_UPDN: begin
                    if (per_sh_r == ZERO_W) begin
                        to_s   = 1'b1;
                        cnt_nx = ZERO_W;
                    end else if (!phase_r) begin
                        if (cnt_r >= per_sh_r) begin
                            phase_nx = 1'b1;
                            cnt_nx   = per_sh_r - ONE_W;
                        end else begin
                            cnt_nx = cnt_r + ONE_W;
                        end
                    end else if (cnt_r == ZERO_W) begin
                        // Leaving 0 after the down phase closes one cycle;
                        // the freshly loaded period decides the next step.
                        to_s     = 1'b1;
                        phase_nx = 1'b0;
                        cnt_nx   = (period == ZERO_W) ? ZERO_W : ONE_W;
                    end else begin
                        cnt_nx = cnt_r - ONE_W;
                    end
                end
                default: begin
                    // Up, and the reserved code which behaves as up.
                    if (cnt_r >= per_sh_r) begin
                        to_s   = 1'b1;
                        cnt_nx = ZERO_W;
                    end else begin
                        cnt_nx = cnt_r + ONE_W;
                    end
                end
            endcase
            if (to_s) begin
                per_sh_nx = period;
                cmp_sh_nx = cmp;
                if (one_shot) begin
                    run_nx = 1'b0;
                end else begin
                    run_nx = running_r;
                end
            end else begin
                run_nx = running_r;
            end
        end else begin
            cnt_nx = cnt_r;
        end
    end

    // Per-channel match, compare output and capture decode; flag-set vector
    always_comb begin
        match_s    = {CH{1'b0}};
        pwm_nx     = {CH{1'b0}};
        cap_s      = {CH{1'b0}};
        cap_val_nx = cap_val_r;
        set_s      = {NF{1'b0}};
        set_s[FLAG_TO] = to_s;
        for (int i = 0; i < CH; i++) begin
            match_s[i] = tick_s & (cnt_nx == cmp_sh_nx[i*W +: W]);
            // Built from next-state values so pwm lines up with cnt.
            pwm_nx[i]  = (cnt_nx < cmp_sh_nx[i*W +: W]);
            cap_s[i]   = en & ev_s[i+1];
            if (cap_s[i]) begin
                cap_val_nx[i*W +: W] = cnt_r;
            end else begin
                cap_val_nx[i*W +: W] = cap_val_r[i*W +: W];
            end
            set_s[flag_match(i)]  = match_s[i];
            set_s[flag_cap(i, CH)] = cap_s[i];
        end
    end

    // State registers; flags are sticky and a set beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= ZERO_W;
            per_sh_r  <= ZERO_W;
            cmp_sh_r  <= {(CH*W){1'b0}};
            cap_val_r <= {(CH*W){1'b0}};
            phase_r   <= 1'b0;
            running_r <= 1'b1;
            pwm_r     <= {CH{1'b0}};
            ris_r     <= {NF{1'b0}};
        end else begin
            cnt_r     <= cnt_nx;
            per_sh_r  <= per_sh_nx;
            cmp_sh_r  <= cmp_sh_nx;
            cap_val_r <= cap_val_nx;
            phase_r   <= phase_nx;
            running_r <= run_nx;
            pwm_r     <= pwm_nx;
            ris_r     <= set_s | (ris_r & ~icr);
        end
    end

    assign cnt     = cnt_r;
    assign cap_val = cap_val_r;
    assign pwm     = pwm_r;
    assign ris     = ris_r;
    assign running = running_r;
    assign mis     = ris_r & im;
    assign irq     = |mis;

endmodule

// File: tb/tb_ef_tcc_mc.sv
// tb_ef_tcc_mc -- directed testbench for ef_tcc_mc (W=16, CH=4, PW=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ef_tcc_mc;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 8;
    localparam int NF = 1 + 2 * CH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            tmr_en;
    logic            one_shot;
    logic [1:0]      dir;
    logic            clk_src;
    logic [PW-1:0]   pre;
    logic [W-1:0]    period;
    logic [CH*W-1:0] cmp;
    logic [2*CH-1:0] cap_edge;
    logic            ext_clk;
    logic [CH-1:0]   cap_in;
    logic [NF-1:0]   im;
    logic [NF-1:0]   icr;
    logic [W-1:0]    cnt;
    logic [CH*W-1:0] cap_val;
    logic [CH-1:0]   pwm;
    logic [NF-1:0]   ris;
    logic [NF-1:0]   mis;
    logic            irq;
    logic            running;

    int tests_run    = 0;
    int tests_failed = 0;
    int rises        = 0;
    int exp_cap      = 0;
    int exp_cnt      = 0;

    always #5 clk = ~clk;

    ef_tcc_mc #(.W(W), .CH(CH), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .tmr_en   (tmr_en),
        .one_shot (one_shot),
        .dir      (dir),
        .clk_src  (clk_src),
        .pre      (pre),
        .period   (period),
        .cmp      (cmp),
        .cap_edge (cap_edge),
        .ext_clk  (ext_clk),
        .cap_in   (cap_in),
        .im       (im),
        .icr      (icr),
        .cnt      (cnt),
        .cap_val  (cap_val),
        .pwm      (pwm),
        .ris      (ris),
        .mis      (mis),
        .irq      (irq),
        .running  (running)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        tmr_en   = 1'b0;
        one_shot = 1'b0;
        dir      = 2'b01;
        clk_src  = 1'b0;
        pre      = 8'd0;
        period   = 16'd20;
        cmp      = {4{16'hFFFF}};
        cap_edge = 8'h00;
        ext_clk  = 1'b0;
        cap_in   = 4'h0;
        im       = 9'h000;
        icr      = 9'h000;

        // Reset state
        wait_neg(3);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_running", running, 1'b1);
        chk("rst_ris", ris, 9'h000);
        chk("rst_irq", irq, 1'b0);
        chk("rst_pwm", pwm, 4'h0);
        chk("rst_capval", cap_val, 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_neg(2);
        chk("idle_up_cnt", cnt, 16'd0);

        // Up mode, period 20, pre 0: timeout every 21 cycles
        tmr_en = 1'b1;
        wait_neg(20);
        chk("up_cnt20", cnt, 16'd20);
        chk("up_no_to", ris[0], 1'b0);
        wait_neg(1);
        chk("up_wrap_cnt", cnt, 16'd0);
        chk("up_to", ris[0], 1'b1);
        icr = 9'h001;
        wait_neg(1);
        icr = 9'h000;
        chk("up_to_clr", ris[0], 1'b0);
        chk("up_cnt1", cnt, 16'd1);
        wait_neg(19);
        chk("up2_cnt20", cnt, 16'd20);
        chk("up2_no_to", ris[0], 1'b0);
        wait_neg(1);
        chk("up2_wrap_cnt", cnt, 16'd0);
        chk("up2_to", ris[0], 1'b1);

        // Period rewritten mid-count takes effect only at the next timeout
        period = 16'd5;
        icr    = 9'h001;
        wait_neg(1);
        icr = 9'h000;
        chk("shadow_cnt1", cnt, 16'd1);
        wait_neg(19);
        chk("shadow_old_cnt20", cnt, 16'd20);
        chk("shadow_old_no_to", ris[0], 1'b0);
        wait_neg(1);
        chk("shadow_wrap", cnt, 16'd0);
        chk("shadow_to", ris[0], 1'b1);
        icr = 9'h001;
        wait_neg(1);
        icr = 9'h000;
        wait_neg(4);
        chk("shadow_new_cnt5", cnt, 16'd5);
        chk("shadow_new_no_to", ris[0], 1'b0);
        wait_neg(1);
        chk("shadow_new_wrap", cnt, 16'd0);
        chk("shadow_new_to", ris[0], 1'b1);

        // Match flag, clear alone vs. set colliding with clear, mis/irq
        tmr_en = 1'b0;
        period = 16'd20;
        cmp    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3};
        icr    = 9'h1FF;
        wait_neg(1);
        icr    = 9'h000;
        tmr_en = 1'b1;
        chk("m_ris_clr", ris, 9'h000);
        chk("m_cnt0", cnt, 16'd0);
        wait_neg(2);
        chk("m_cnt2", cnt, 16'd2);
        chk("m_pwm_hi", pwm[0], 1'b1);
        wait_neg(1);
        chk("m_cnt3", cnt, 16'd3);
        chk("m_pwm_lo", pwm[0], 1'b0);
        chk("m_set", ris[1], 1'b1);
        icr = 9'h002;
        wait_neg(1);
        icr = 9'h000;
        chk("m_clr_alone", ris[1], 1'b0);
        chk("m_cnt4", cnt, 16'd4);
        wait_neg(19);
        chk("m2_cnt2", cnt, 16'd2);
        chk("m2_still_clr", ris[1], 1'b0);
        icr = 9'h002;
        wait_neg(1);
        icr = 9'h000;
        chk("m2_cnt3", cnt, 16'd3);
        chk("m_set_wins", ris[1], 1'b1);
        im = 9'h002;
        #1;
        chk("m_irq_on", irq, 1'b1);
        chk("m_mis", mis, 9'h002);
        im = 9'h000;
        #1;
        chk("m_irq_off", irq, 1'b0);

        // Up/down, period 10: 0..10..0, pwm boundaries, one TO per 20 ticks
        tmr_en = 1'b0;
        dir    = 2'b10;
        period = 16'd10;
        cmp    = {16'hFFFF, 16'd0, 16'd11, 16'd4};
        icr    = 9'h1FF;
        wait_neg(1);
        icr    = 9'h000;
        tmr_en = 1'b1;
        chk("ud_cnt0", cnt, 16'd0);
        for (int k = 1; k <= 20; k++) begin
            wait_neg(1);
            exp_cnt = (k <= 10) ? k : 20 - k;
            chk($sformatf("ud_cnt_%0d", k), cnt, exp_cnt);
            chk($sformatf("ud_pwm0_%0d", k), pwm[0], (exp_cnt < 4) ? 1'b1 : 1'b0);
            chk($sformatf("ud_pwm_gt_per_%0d", k), pwm[1], 1'b1);
            chk($sformatf("ud_pwm_zero_%0d", k), pwm[2], 1'b0);
        end
        chk("ud_no_to_yet", ris[0], 1'b0);
        wait_neg(1);
        chk("ud_leave0_cnt", cnt, 16'd1);
        chk("ud_to", ris[0], 1'b1);

        // Down one-shot, period 20, pre 3: TO on 84th cycle, then hold
        tmr_en   = 1'b0;
        dir      = 2'b00;
        period   = 16'd20;
        pre      = 8'd3;
        one_shot = 1'b1;
        cmp      = {4{16'hFFFF}};
        icr      = 9'h1FF;
        wait_neg(1);
        icr = 9'h000;
        chk("dn_load", cnt, 16'd20);
        chk("dn_running", running, 1'b1);
        tmr_en = 1'b1;
        wait_neg(83);
        chk("dn_cnt0", cnt, 16'd0);
        chk("dn_no_to", ris[0], 1'b0);
        chk("dn_still_run", running, 1'b1);
        wait_neg(1);
        chk("dn_to", ris[0], 1'b1);
        chk("dn_stopped", running, 1'b0);
        chk("dn_reload", cnt, 16'd20);
        icr = 9'h001;
        wait_neg(1);
        icr = 9'h000;
        wait_neg(200);
        chk("dn_no_second_to", ris[0], 1'b0);
        chk("dn_hold", cnt, 16'd20);
        chk("dn_hold_stop", running, 1'b0);

        // External count source and capture on channel 1 (rising edge only)
        tmr_en   = 1'b0;
        one_shot = 1'b0;
        dir      = 2'b01;
        pre      = 8'd0;
        period   = 16'd1000;
        clk_src  = 1'b1;
        cap_edge = 8'b0000_0100;
        im       = 9'h040;
        icr      = 9'h1FF;
        wait_neg(1);
        icr    = 9'h000;
        tmr_en = 1'b1;
        chk("ext_cnt0", cnt, 16'd0);
        for (int i = 0; i < 300; i++) begin
            if (i == 2) chk("ext_lat_lo", cnt, 16'd0);
            if (i == 3) chk("ext_lat_hi", cnt, 16'd1);
            if (i == 152) chk("cap_not_yet", ris[6], 1'b0);
            if (i == 153) begin
                chk("cap_flag", ris[6], 1'b1);
                chk("cap_val1", cap_val[31:16], exp_cap);
                chk("cap_irq", irq, 1'b1);
            end
            if (i == 205) chk("cap_fall_ignored", ris[6], 1'b0);
            if (i == 253) begin
                chk("cap2_flag", ris[6], 1'b1);
                chk("cap2_val1", cap_val[31:16], exp_cap);
            end
            if (i == 150 || i == 250) begin
                cap_in[1] = 1'b1;
                exp_cap   = rises;
            end
            if (i == 160) icr = 9'h040;
            if (i == 161) icr = 9'h000;
            if (i == 200) cap_in[1] = 1'b0;
            if (i % 35 == 0) begin
                ext_clk = ~ext_clk;
                if (ext_clk) rises++;
            end
            wait_neg(1);
        end
        chk("ext_cnt_end", cnt, rises);

        // en=0 freezes count and capture, icr still clears
        en        = 1'b0;
        clk_src   = 1'b0;
        cap_in[1] = 1'b0;
        icr       = 9'h040;
        wait_neg(1);
        icr = 9'h000;
        chk("dis_icr_clears", ris[6], 1'b0);
        wait_neg(5);
        chk("dis_cnt_frozen", cnt, 16'd5);
        cap_in[1] = 1'b1;
        wait_neg(5);
        chk("dis_no_cap_flag", ris[6], 1'b0);
        chk("dis_capval_held", cap_val[31:16], 16'd4);
        en = 1'b1;
        wait_neg(1);
        chk("en_resume", cnt, 16'd6);

        // Reset mid-count, then restart from the idle start value
        wait_neg(3);
        rst_n  = 1'b0;
        tmr_en = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt, 16'd0);
        chk("mid_rst_capval", cap_val, 64'd0);
        chk("mid_rst_ris", ris, 9'h000);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_running", running, 1'b1);
        wait_neg(1);
        rst_n = 1'b1;
        wait_neg(1);
        chk("post_rst_load", cnt, 16'd0);
        tmr_en = 1'b1;
        wait_neg(3);
        chk("post_rst_count", cnt, 16'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
